grant_responder: RTL

- Responder end of the request/grant/revoke handshake. Arbitrates N_REQ requesters, each driving a level request.
- Issues a one-hot grant and enforces a maximum hold time: when others are waiting, it asks the owner to revoke (give up) the grant.
- Forcibly reclaims the grant if the owner ignores the revoke request.
- Sits between the requesting FSMs and the shared resource they contend for.

---
 rtl/grant_pkg.sv | 25 ++
 rtl/grant_responder_if.sv | 25 ++
 rtl/grant_responder_rr_pick.sv | 31 +++
 rtl/grant_responder.sv | 115 +++++++++++
 4 files changed

// File: rtl/grant_pkg.sv
// Shared types and helpers for the request/grant/revoke responder.
package grant_pkg;

   // Responder FSM states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      REVOKE = 2'd2
   } ty_STATE_RSP;

   // Widest one-hot vector the index helper handles.
   localparam int unsigned OH_MAX_W = 32;

   // One-hot to binary index. Bits are OR-combined, so a legal one-hot
   // (or zero) input gives the exact index; zero maps to 0.
   function automatic logic [31:0] oh2idx(input logic [OH_MAX_W-1:0] oh);
      logic [31:0] idx;
      idx = '0;
      for (int i = 0; i < OH_MAX_W; i++) begin
         if (oh[i]) idx = idx | 32'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/grant_responder_if.sv
// Handshake bundle between the requesting FSMs and the grant responder.
interface grant_responder_if #(
   parameter int N_REQ = 4
);
   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0] i_req;
   logic [N_REQ-1:0] o_grant;
   logic [N_REQ-1:0] o_revoke;
   logic [IDX_W-1:0] o_ownerIdx;
   logic             o_busy;
   logic             o_revokeTimeout;

   // Requester side: drives requests, observes grant/revoke.
   modport master (
      output i_req,
      input  o_grant, o_revoke, o_ownerIdx, o_busy, o_revokeTimeout
   );

   // Responder side.
   modport slave (
      input  i_req,
      output o_grant, o_revoke, o_ownerIdx, o_busy, o_revokeTimeout
   );
endinterface

// File: rtl/grant_responder_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping from N_REQ-1 back to 0. Supports N_REQ up to 32.
module rr_pick
   import grant_pkg::*;
#(
   parameter int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   // Scan offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      int c;
      onehot = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         c = (int'(ptr) + k) % N_REQ;
         if (req[c]) begin
            onehot    = '0;
            onehot[c] = 1'b1;
         end
      end
      valid = |req;
      idx   = IDX_W'(oh2idx(OH_MAX_W'(onehot)));
   end

endmodule

// File: rtl/grant_responder.sv
// Responder end of the request/grant/revoke handshake: round-robin grant,
// hold-time limited revoke, and forced reclaim when a revoke is ignored.
module grant_responder
   import grant_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int MAX_HOLD       = 16,
   parameter int REVOKE_TIMEOUT = 8
) (
   input  logic               i_ck,
   input  logic               i_arst,
   grant_responder_if.slave   bus
);

   localparam int IDX_W  = $clog2(N_REQ);
   // +1 keeps the width non-zero when the limit is 1, and lets the revoke
   // counter step one past its terminal value without wrapping.
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam int REV_W  = $clog2(REVOKE_TIMEOUT + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [REV_W-1:0]  REV_LAST  = REV_W'(REVOKE_TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

   ty_STATE_RSP       state;
   logic [IDX_W-1:0]  ptr;
   logic [HOLD_W-1:0] hold_cnt;
   logic [REV_W-1:0]  revoke_cnt;

   logic              pick_vld;
   logic [IDX_W-1:0]  pick_idx;
   logic [N_REQ-1:0]  pick_oh;
   logic              owner_req;
   logic              competitor;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (bus.i_req),
      .ptr    (ptr),
      .valid  (pick_vld),
      .idx    (pick_idx),
      .onehot (pick_oh)
   );

   // The registered grant is the owner mask; derive release and contention.
   always_comb begin
      owner_req  = |(bus.i_req & bus.o_grant);
      competitor = |(bus.i_req & ~bus.o_grant);
   end

   // Responder FSM with registered outputs; any drop returns through IDLE,
   // which gives the guaranteed zero-grant handover cycle.
   always_ff @(posedge i_ck or posedge i_arst) begin
      if (i_arst) begin
         state               <= IDLE;
         ptr                 <= '0;
         hold_cnt            <= '0;
         revoke_cnt          <= '0;
         bus.o_grant         <= '0;
         bus.o_revoke        <= '0;
         bus.o_ownerIdx      <= '0;
         bus.o_busy          <= 1'b0;
         bus.o_revokeTimeout <= 1'b0;
      end else begin
         bus.o_revokeTimeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  state          <= GRANT;
                  bus.o_grant    <= pick_oh;
                  bus.o_ownerIdx <= pick_idx;
                  bus.o_busy     <= 1'b1;
                  hold_cnt       <= '0;
                  ptr            <= (pick_idx == IDX_LAST) ? '0 : pick_idx + IDX_W'(1);
               end
            end
            GRANT: begin
               if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + HOLD_W'(1);
               if (!owner_req) begin
                  // Release beats everything, including a due revoke.
                  state          <= IDLE;
                  bus.o_grant    <= '0;
                  bus.o_ownerIdx <= '0;
                  bus.o_busy     <= 1'b0;
               end else if (hold_cnt == HOLD_LAST && competitor) begin
                  state        <= REVOKE;
                  bus.o_revoke <= bus.o_grant;
                  revoke_cnt   <= '0;
               end
            end
            REVOKE: begin
               revoke_cnt <= revoke_cnt + REV_W'(1);
               // Competitors leaving does not cancel; only the owner ends it.
               if (!owner_req || revoke_cnt == REV_LAST) begin
                  state               <= IDLE;
                  bus.o_grant         <= '0;
                  bus.o_revoke        <= '0;
                  bus.o_ownerIdx      <= '0;
                  bus.o_busy          <= 1'b0;
                  bus.o_revokeTimeout <= owner_req;
               end
            end
            default: begin
               state          <= IDLE;
               hold_cnt       <= '0;
               revoke_cnt     <= '0;
               bus.o_grant    <= '0;
               bus.o_revoke   <= '0;
               bus.o_ownerIdx <= '0;
               bus.o_busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
